timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, counter width.
REQ-002 Parameter PSC_W, default 4, prescaler width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port cfg_we  input  1  config write strobe, one write per cycle.
REQ-006 Port cfg_addr  input  2  register select: 0 PERIOD, 1 PRESCALE, 2 MODE, 3 reserved.
REQ-007 Port cfg_wdata  input  CNT_W  config write data.
REQ-008 Port start  input  1  start or resume request, level sampled each cycle.
REQ-009 Port stop  input  1  pause or abort request.
REQ-010 Port irq_clr  input  1  clears sticky irq.
REQ-011 Port count  output  CNT_W  current count value, registered.
REQ-012 Port busy  output  1  high in RUN or HOLD.
REQ-013 Port tick  output  1  registered one-cycle pulse on terminal-count wrap.
REQ-014 Port irq  output  1  sticky interrupt, registered.

Function
REQ-015 Registers: PERIOD uses CNT_W bits; PRESCALE uses cfg_wdata[PSC_W-1:0]; MODE bit0 is periodic (1) or one-shot (0), bit1 is irq_en; writes to addr 3 are ignored; writes take effect the next cycle in any state.
REQ-016 FSM states are IDLE, RUN and HOLD; busy = (state != IDLE).
REQ-017 IDLE with start and without stop: go to RUN; count <= 0; prescaler <= 0.
REQ-018 RUN: the prescaler counts 0..PRESCALE; the cycle it equals PRESCALE is a step cycle, and the prescaler then returns to 0; count changes only on step cycles.
REQ-019 Step with count >= PERIOD: count <= 0; tick = 1 next cycle; periodic mode stays in RUN; one-shot mode goes to IDLE.
REQ-020 Step with count < PERIOD: count <= count + 1; the CNT_W-bit result never exceeds PERIOD.
REQ-021 The >= compare makes a PERIOD written below the current count wrap on the next step.
REQ-022 PERIOD = 0 gives a tick on every step.
REQ-023 Step spacing is PRESCALE+1 cycles; with PRESCALE = 0, count advances every cycle.
REQ-024 Latency: start sampled in cycle t gives RUN with count = 0 at t+1, and count = 1 at t+1+(PRESCALE+1).
REQ-025 RUN with stop: go to HOLD; count and prescaler are frozen; an in-cycle step is suppressed.
REQ-026 HOLD with start and without stop: return to RUN and resume from the frozen count and prescaler.
REQ-027 HOLD with stop: go to IDLE; count <= 0.
REQ-028 start in RUN is ignored; stop in IDLE is ignored; when start and stop are both high, stop wins.
REQ-029 irq <= 1 the cycle tick is set, if irq_en = 1; otherwise irq_clr clears it; set wins over a simultaneous clear.
REQ-030 Clearing irq_en does not clear a pending irq.

Reset
REQ-031 While rst_n = 0, all flops take reset values immediately, independent of clk.
REQ-032 Reset values: state IDLE, count 0, prescaler 0, tick 0, irq 0, busy 0, PERIOD all ones, PRESCALE 0, MODE = 1 (periodic, irq disabled).
REQ-033 Reset mid-RUN aborts the operation; after release, the block waits in IDLE for start.

Structure
REQ-034 Package timer_ctrl_pkg holds the state enum, the register address constants (ADDR_PERIOD, ADDR_PRESCALE, ADDR_MODE), the MODE bit indices and the register reset values.
REQ-035 The prescaler is a sub-module timer_ctrl_psc with inputs run, clear and div, and a step output; the FSM, registers and count stay in timer_ctrl.

Verification
REQ-036 Defaults, start pulse at cycle t: count 0 at t+1, 255 at t+256, 0 with tick = 1 at t+257; the block stays busy; ticks repeat every 256 cycles; irq stays 0.
REQ-037 PERIOD = 3, PRESCALE = 2, MODE = 0, start: count steps 0,1,2,3 every 3 cycles, then wraps to 0 with tick = 1 and busy = 0 in the same cycle; there is no further counting.
REQ-038 PRESCALE = 0, stop at count = 5: count held at 5 for 10 cycles with busy = 1; start gives count = 6 on the next step; stop twice gives IDLE with count = 0.
REQ-039 MODE = 3, PERIOD = 4: irq rises with the first tick; irq_clr in the same cycle as a tick leaves irq = 1; a later irq_clr alone gives irq = 0.
REQ-040 RUN with count = 10, write PERIOD = 2: the next step gives count = 0 and tick = 1; after that the block counts 0..2.
REQ-041 start and stop high together in IDLE: stays IDLE; rst_n low mid-RUN with count = 7: count, busy, irq and tick are 0 immediately, and PERIOD reads back 255.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared types and constants for the timer controller
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_PERIOD   = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_MODE     = 2'd2;

    localparam int MODE_PERIODIC_BIT = 0;
    localparam int MODE_IRQ_EN_BIT   = 1;

    // PERIOD resets to all ones at whatever CNT_W the top is built with.
    localparam logic [1:0] MODE_RESET     = 2'b01;
    localparam logic       PRESCALE_RESET = 1'b0;
    localparam logic       PERIOD_RESET   = 1'b1;

endpackage

// File: rtl/timer_ctrl_psc.sv
// rtl/timer_ctrl_psc.sv - prescaler producing one step every div+1 running cycles
module timer_ctrl_psc #(
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clear,
    input  logic [PSC_W-1:0] div,
    output logic             step
);

    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_d;

    // >= rather than == so a PRESCALE lowered mid-count steps at once instead of wrapping.
    assign step = run && (psc_q >= div);

    always_comb begin
        psc_d = psc_q;
        if (clear) begin
            psc_d = '0;
        end else if (run) begin
            psc_d = step ? '0 : psc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - prescaled periodic/one-shot timer with pause, tick and sticky irq
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_clr,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             irq
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [PSC_W-1:0] div_q, div_d;
    logic [1:0]       mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             irq_q, irq_d;
    logic             psc_run;
    logic             psc_clear;
    logic             step;

    timer_ctrl_psc #(
        .PSC_W (PSC_W)
    ) u_psc (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (psc_run),
        .clear (psc_clear),
        .div   (div_q),
        .step  (step)
    );

    always_comb begin
        period_d = period_q;
        div_d    = div_q;
        mode_d   = mode_q;
        if (cfg_we) begin
            case (cfg_addr)
                ADDR_PERIOD:   period_d = cfg_wdata;
                ADDR_PRESCALE: div_d    = cfg_wdata[PSC_W-1:0];
                ADDR_MODE:     mode_d   = cfg_wdata[1:0];
                default:       ;
            endcase
        end
    end

    // stop takes priority everywhere and also masks the step of the cycle it arrives in.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tick_d    = 1'b0;
        psc_run   = 1'b0;
        psc_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d   = ST_RUN;
                    count_d   = '0;
                    psc_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_HOLD;
                end else begin
                    psc_run = 1'b1;
                    if (step) begin
                        if (count_q >= period_q) begin
                            count_d = '0;
                            tick_d  = 1'b1;
                            if (!mode_q[MODE_PERIODIC_BIT]) begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    count_d   = '0;
                    psc_clear = 1'b1;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                count_d   = '0;
                psc_clear = 1'b1;
            end
        endcase
    end

    always_comb begin
        irq_d = irq_q;
        if (tick_d && mode_q[MODE_IRQ_EN_BIT]) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            period_q <= {CNT_W{PERIOD_RESET}};
            div_q    <= {PSC_W{PRESCALE_RESET}};
            mode_q   <= MODE_RESET;
            tick_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            div_q    <= div_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            irq_q    <= irq_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q != ST_IDLE);
    assign tick  = tick_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed vector bench for timer_ctrl
module tb_timer_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       start;
    logic       stop;
    logic       irq_clr;
    logic [7:0] count;
    logic       busy;
    logic       tick;
    logic       irq;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       st;
        logic       sp;
        logic       clr;
        logic [7:0] e_count;
        logic       e_busy;
        logic       e_tick;
        logic       e_irq;
    } vec_t;

    vec_t tbl[21];

    timer_ctrl #(
        .CNT_W (8),
        .PSC_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .start     (start),
        .stop      (stop),
        .irq_clr   (irq_clr),
        .count     (count),
        .busy      (busy),
        .tick      (tick),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                                input logic st, input logic sp, input logic clr,
                                input logic [7:0] e_count, input logic e_busy,
                                input logic e_tick, input logic e_irq);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata;
        v.st = st; v.sp = sp; v.clr = clr;
        v.e_count = e_count; v.e_busy = e_busy; v.e_tick = e_tick; v.e_irq = e_irq;
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_count(input int val, input int max_cyc);
        int k;
        k = 0;
        while (int'(count) != val && k < max_cyc) begin
            cycle();
            k++;
        end
        n_vec++;
        if (int'(count) != val) begin
            n_bad++;
            $display("FAIL wait_count: count %0d, wanted %0d within %0d cycles", count, val, max_cyc);
        end
    endtask

    task automatic stop_to_idle();
        stop = 1'b1;
        cycle();
        cycle();
        stop = 1'b0;
        chk("stop2 busy", busy, 0);
        chk("stop2 count", count, 0);
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0;
        start = 1'b0; stop = 1'b0; irq_clr = 1'b0;

        // PERIOD 3, PRESCALE 2, one-shot: steps every 3 cycles, wrap drops busy with tick
        tbl[0]  = mk(1, 2'd0, 8'd3, 0, 0, 0, 8'd0, 0, 0, 0);
        tbl[1]  = mk(1, 2'd1, 8'd2, 0, 0, 0, 8'd0, 0, 0, 0);
        tbl[2]  = mk(1, 2'd2, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0);
        tbl[3]  = mk(0, 2'd0, 8'd0, 1, 0, 0, 8'd0, 1, 0, 0);
        tbl[4]  = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd0, 1, 0, 0);
        tbl[5]  = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd0, 1, 0, 0);
        tbl[6]  = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd1, 1, 0, 0);
        tbl[7]  = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd1, 1, 0, 0);
        tbl[8]  = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd1, 1, 0, 0);
        tbl[9]  = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd2, 1, 0, 0);
        tbl[10] = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd2, 1, 0, 0);
        tbl[11] = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd2, 1, 0, 0);
        tbl[12] = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd3, 1, 0, 0);
        tbl[13] = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd3, 1, 0, 0);
        tbl[14] = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd3, 1, 0, 0);
        tbl[15] = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 0);
        tbl[16] = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0);
        tbl[17] = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0);
        tbl[18] = mk(0, 2'd0, 8'd0, 0, 1, 0, 8'd0, 0, 0, 0);
        tbl[19] = mk(0, 2'd0, 8'd0, 1, 1, 0, 8'd0, 0, 0, 0);
        tbl[20] = mk(0, 2'd0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0);

        @(posedge clk);
        #3;
        chk("reset count", count, 0);
        chk("reset busy", busy, 0);
        chk("reset tick", tick, 0);
        chk("reset irq", irq, 0);
        #4 rst_n = 1'b1;
        cycle();

        // defaults: PERIOD 255, PRESCALE 0, periodic, irq disabled
        pulse_start();
        chk("def t+1 count", count, 0);
        chk("def t+1 busy", busy, 1);
        for (int i = 1; i <= 255; i++) begin
            cycle();
            chk($sformatf("def count %0d", i), count, i);
        end
        cycle();
        chk("def wrap count", count, 0);
        chk("def wrap tick", tick, 1);
        chk("def wrap busy", busy, 1);
        chk("def wrap irq", irq, 0);
        for (int i = 1; i <= 255; i++) begin
            cycle();
            chk($sformatf("def2 tick %0d", i), tick, 0);
        end
        cycle();
        chk("def 2nd tick", tick, 1);
        chk("def 2nd irq", irq, 0);
        stop_to_idle();

        for (int i = 0; i < 21; i++) begin
            cfg_we = tbl[i].we; cfg_addr = tbl[i].addr; cfg_wdata = tbl[i].wdata;
            start = tbl[i].st; stop = tbl[i].sp; irq_clr = tbl[i].clr;
            cycle();
            chk($sformatf("vec%0d count", i), count, tbl[i].e_count);
            chk($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d tick", i), tick, tbl[i].e_tick);
            chk($sformatf("vec%0d irq", i), irq, tbl[i].e_irq);
        end
        cfg_we = 1'b0; start = 1'b0; stop = 1'b0; irq_clr = 1'b0;

        // pause at 5, resume, then abort
        wr(2'd0, 8'd20); wr(2'd1, 8'd0); wr(2'd2, 8'd1);
        pulse_start();
        wait_count(5, 20);
        stop = 1'b1; cycle(); stop = 1'b0;
        chk("hold count", count, 5);
        chk("hold busy", busy, 1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk($sformatf("hold%0d count", i), count, 5);
            chk($sformatf("hold%0d busy", i), busy, 1);
        end
        pulse_start();
        chk("resume count", count, 5);
        cycle();
        chk("resume step", count, 6);
        stop = 1'b1;
        cycle();
        chk("stop1 count", count, 6);
        chk("stop1 busy", busy, 1);
        cycle();
        stop = 1'b0;
        chk("stop2 count", count, 0);
        chk("stop2 busy", busy, 0);

        // irq: set with first tick, set beats clear, clear alone drops it
        wr(2'd0, 8'd4); wr(2'd1, 8'd0); wr(2'd2, 8'd3);
        pulse_start();
        repeat (4) cycle();
        chk("irq pre count", count, 4);
        chk("irq pre", irq, 0);
        cycle();
        chk("irq first tick", tick, 1);
        chk("irq first set", irq, 1);
        repeat (4) cycle();
        chk("irq wrap cycle count", count, 4);
        irq_clr = 1'b1; cycle(); irq_clr = 1'b0;
        chk("irq set>clr tick", tick, 1);
        chk("irq set>clr", irq, 1);
        irq_clr = 1'b1; cycle(); irq_clr = 1'b0;
        chk("irq clr alone", irq, 0);
        chk("irq clr count", count, 1);
        stop_to_idle();

        // PERIOD lowered under the running count
        wr(2'd0, 8'd20); wr(2'd1, 8'd3);
        pulse_start();
        wait_count(10, 60);
        wr(2'd0, 8'd2);
        chk("lower count", count, 10);
        repeat (2) cycle();
        chk("lower hold", count, 10);
        cycle();
        chk("lower wrap count", count, 0);
        chk("lower wrap tick", tick, 1);
        chk("lower wrap irq", irq, 1);
        wr(2'd2, 8'd1);
        chk("irq_en off keeps irq", irq, 1);
        repeat (3) cycle();
        chk("lower c1", count, 1);
        repeat (4) cycle();
        chk("lower c2", count, 2);
        repeat (4) cycle();
        chk("lower c0", count, 0);
        chk("lower tick2", tick, 1);
        chk("lower irq kept", irq, 1);

        // asynchronous reset mid-run
        wr(2'd0, 8'd20);
        wait_count(7, 60);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst count", count, 0);
        chk("async rst busy", busy, 0);
        chk("async rst irq", irq, 0);
        chk("async rst tick", tick, 0);
        #1 rst_n = 1'b1;
        cycle();
        chk("post rst idle", busy, 0);
        wr(2'd3, 8'd2);
        pulse_start();
        chk("post rst start", count, 0);
        repeat (255) cycle();
        chk("post rst count 255", count, 255);
        chk("post rst busy", busy, 1);
        chk("post rst irq", irq, 0);
        chk("post rst tick0", tick, 0);
        cycle();
        chk("post rst wrap", count, 0);
        chk("post rst tick", tick, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
